// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: ALU select decoder with ID/EX control register and multi-cycle mult/div sequencer
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   aluop, func       main-decoder ALU op and R-type function field
//   stall_in, flush   hazard-unit hold and branch/jump kill of EX
//   ex_valid, ex_alusel, ex_illegal   registered ID/EX control
//   stall_out         combinational multi-cycle stall request
//   mdu_busy, mdu_op  sequencer busy flag and op (0 mult, 1 div)
//   hilo_we           one-cycle HI/LO write pulse
module alu_ctrl_pipe #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] aluop,
  input  logic [5:0] func,
  input  logic       stall_in,
  input  logic       flush,
  output logic       ex_valid,
  output logic [3:0] ex_alusel,
  output logic       ex_illegal,
  output logic       stall_out,
  output logic       mdu_busy,
  output logic       mdu_op,
  output logic       hilo_we
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] MUL_LAT = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES - 1);
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] sel;
  logic illegal, mdu_start, ex_load, done_flag, done_nx, op_nx;
  always_comb begin
    sel = 4'd0;
    if (aluop == 4'b0000)
      case (func)
        6'b100000: sel = 4'd1;
        6'b100010: sel = 4'd2;
        6'b101010: sel = 4'd3;
        6'b100100: sel = 4'd4;
        6'b100101: sel = 4'd5;
        6'b100110: sel = 4'd10;
        6'b100111: sel = 4'd11;
        6'b000000: sel = 4'd12;
        6'b000010: sel = 4'd13;
        6'b011000: sel = ENABLE_MDU ? 4'd14 : 4'd0;
        6'b011010: sel = ENABLE_MDU ? 4'd15 : 4'd0;
        default:   sel = 4'd0;
      endcase
    else
      case (aluop)
        4'b0011: sel = 4'd6;
        4'b1011: sel = 4'd7;
        4'b0100: sel = 4'd8;
        4'b0010: sel = 4'd9;
        default: sel = 4'd0;
      endcase
  end
  // select 0 is never a legal encoding, so it doubles as the illegal marker
  assign illegal = sel == 4'd0;
  // done_flag blocks a second start while a finished mult/div is held in EX
  assign mdu_start = ENABLE_MDU && ex_valid && ex_alusel[3:1] == 3'b111 && state == IDLE && !done_flag;
  assign stall_out = mdu_start || state == BUSY;
  assign ex_load = !flush && !stall_in && !stall_out;
  assign mdu_busy = state == BUSY;
  assign hilo_we = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_alusel <= 4'd0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_alusel <= 4'd0;
      ex_illegal <= 1'b0;
    end else if (ex_load) begin
      ex_valid <= id_valid;
      ex_alusel <= sel;
      ex_illegal <= illegal && id_valid;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    op_nx = mdu_op;
    case (state)
      IDLE: begin
        state_nx = mdu_start ? BUSY : IDLE;
        cnt_nx = mdu_start ? (ex_alusel[0] ? DIV_LAT : MUL_LAT) : cnt;
        op_nx = mdu_start ? ex_alusel[0] : mdu_op;
      end
      BUSY: begin
        state_nx = cnt == 8'd0 ? DONE : BUSY;
        cnt_nx = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      cnt_nx = 8'd0;
    end
    // a load at the DONE edge moves the op out of EX, so clearing wins over setting
    done_nx = (flush || ex_load) ? 1'b0 : (state == DONE ? 1'b1 : done_flag);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      mdu_op <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mdu_op <= op_nx;
      done_flag <= done_nx;
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed self-checking bench for alu_ctrl_pipe
module tb_alu_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [3:0] aluop = 4'd0;
  logic [5:0] func = 6'd0;
  logic stall_in = 1'b0;
  logic flush = 1'b0;
  logic ex_valid, ex_illegal, stall_out, mdu_busy, mdu_op, hilo_we;
  logic [3:0] ex_alusel;
  logic v0, ill0, stall0, busy0, op0, hw0;
  logic [3:0] sel0;
  int checks = 0;
  int failures = 0;
  int hilo_cnt = 0;
  int h0 = 0;
  logic s0_seen = 1'b0;
  always #5 clk = ~clk;
  alu_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .aluop(aluop), .func(func),
    .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_alusel(ex_alusel),
    .ex_illegal(ex_illegal), .stall_out(stall_out), .mdu_busy(mdu_busy),
    .mdu_op(mdu_op), .hilo_we(hilo_we)
  );
  alu_ctrl_pipe #(.ENABLE_MDU(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .aluop(aluop), .func(func),
    .stall_in(stall_in), .flush(flush), .ex_valid(v0), .ex_alusel(sel0),
    .ex_illegal(ill0), .stall_out(stall0), .mdu_busy(busy0),
    .mdu_op(op0), .hilo_we(hw0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    hilo_cnt += int'(hilo_we);
    s0_seen = s0_seen | stall0 | busy0 | hw0 | op0;
  endtask
  task automatic set_id(input logic v, input logic [3:0] op, input logic [5:0] fn);
    id_valid = v;
    aluop = op;
    func = fn;
  endtask
  logic [3:0] t_op [15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                            4'b0011, 4'b1011, 4'b0100, 4'b0010, 4'b0111, 4'b0000, 4'b0001};
  logic [5:0] t_fn [15] = '{6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000000, 6'b000010,
                            6'b011000, 6'b011010, 6'b111111, 6'b000000, 6'b100000, 6'b111111, 6'b100000};
  logic [3:0] t_sel [15] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13,
                             4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_sel", ex_alusel, 0);
    check("rst_ill", ex_illegal, 0);
    check("rst_stall", stall_out, 0);
    check("rst_busy", mdu_busy, 0);
    check("rst_op", mdu_op, 0);
    check("rst_hilo", hilo_we, 0);
    rst_n = 1'b1;
    set_id(1, 4'b0000, 6'b100000);
    step();
    check("add_valid", ex_valid, 1);
    check("add_sel", ex_alusel, 1);
    check("add_stall", stall_out, 0);
    check("add_ill", ex_illegal, 0);
    for (int i = 0; i < 15; i++) begin
      set_id(1, t_op[i], t_fn[i]);
      step();
      check($sformatf("sweep_sel%0d", i), ex_alusel, t_sel[i]);
      check($sformatf("sweep_ill%0d", i), ex_illegal, t_sel[i] == 4'd0);
      check($sformatf("sweep_sel0_%0d", i), sel0, t_sel[i]);
      check($sformatf("sweep_stall%0d", i), stall_out, 0);
    end
    set_id(0, 4'b0111, 6'd0);
    step();
    check("bubble_valid", ex_valid, 0);
    check("bubble_ill", ex_illegal, 0);
    // mult, MUL_CYCLES=4
    set_id(1, 4'b0000, 6'b011000);
    step();
    check("mul_sel", ex_alusel, 14);
    check("mul_stall_t", stall_out, 1);
    check("mul_busy_t", mdu_busy, 0);
    check("mdu0_sel", sel0, 0);
    check("mdu0_ill", ill0, 1);
    check("mdu0_valid", v0, 1);
    set_id(1, 4'b0000, 6'b100000);
    h0 = hilo_cnt;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("mul_busy%0d", i), mdu_busy, 1);
      check($sformatf("mul_stall%0d", i), stall_out, 1);
      check($sformatf("mul_hold%0d", i), ex_alusel, 14);
      check($sformatf("mul_nohilo%0d", i), hilo_we, 0);
    end
    step();
    check("mul_hilo", hilo_we, 1);
    check("mul_done_busy", mdu_busy, 0);
    check("mul_done_stall", stall_out, 0);
    check("mul_op", mdu_op, 0);
    step();
    check("mul_next_sel", ex_alusel, 1);
    check("mul_next_hilo", hilo_we, 0);
    check("mul_pulses", hilo_cnt - h0, 1);
    // div, flushed in BUSY cycle 10
    set_id(1, 4'b0000, 6'b011010);
    step();
    check("div_sel", ex_alusel, 15);
    check("div_stall_t", stall_out, 1);
    check("div0_ill", ill0, 1);
    set_id(1, 4'b0000, 6'b100000);
    h0 = hilo_cnt;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("div_busy%0d", i), mdu_busy, 1);
    end
    check("div_op", mdu_op, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_busy", mdu_busy, 0);
    check("flush_stall", stall_out, 0);
    check("flush_hilo", hilo_we, 0);
    step();
    check("flush_next_valid", ex_valid, 1);
    check("flush_next_sel", ex_alusel, 1);
    repeat (30) step();
    check("flush_pulses", hilo_cnt - h0, 0);
    // mult with stall_in held through DONE
    set_id(1, 4'b0000, 6'b011000);
    step();
    check("smul_stall_t", stall_out, 1);
    set_id(1, 4'b0000, 6'b100000);
    stall_in = 1'b1;
    h0 = hilo_cnt;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("smul_busy%0d", i), mdu_busy, 1);
    end
    step();
    check("smul_hilo", hilo_we, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("smul_nohilo%0d", i), hilo_we, 0);
      check($sformatf("smul_nobusy%0d", i), mdu_busy, 0);
      check($sformatf("smul_nostall%0d", i), stall_out, 0);
      check($sformatf("smul_hold%0d", i), ex_alusel, 14);
    end
    check("smul_pulses", hilo_cnt - h0, 1);
    stall_in = 1'b0;
    step();
    check("smul_release", ex_alusel, 1);
    // back-to-back mult
    set_id(1, 4'b0000, 6'b011000);
    step();
    check("b2b_stall_t", stall_out, 1);
    repeat (4) step();
    step();
    check("b2b_hilo1", hilo_we, 1);
    step();
    check("b2b_sel2", ex_alusel, 14);
    check("b2b_stall2", stall_out, 1);
    check("b2b_hilo_off", hilo_we, 0);
    set_id(1, 4'b0000, 6'b100000);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("b2b_busy%0d", i), mdu_busy, 1);
    end
    step();
    check("b2b_hilo2", hilo_we, 1);
    step();
    check("b2b_next_sel", ex_alusel, 1);
    // asynchronous reset mid-BUSY
    set_id(1, 4'b0000, 6'b011000);
    step();
    set_id(1, 4'b0000, 6'b100000);
    step();
    step();
    check("arst_pre_busy", mdu_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", mdu_busy, 0);
    check("arst_valid", ex_valid, 0);
    check("arst_stall", stall_out, 0);
    check("arst_hilo", hilo_we, 0);
    check("arst_sel", ex_alusel, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    h0 = hilo_cnt;
    repeat (10) step();
    check("arst_pulses", hilo_cnt - h0, 0);
    check("arst_reload", ex_alusel, 1);
    check("mdu0_never", s0_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, multi-cycle-aware successor to the ALU control decoder in the pipelined MIPS core. Decodes `{aluop, func}` in ID into a 4-bit ALU select, covering the existing opcode set plus xor, nor, sll, srl, mult and div. Latches the select into an ID/EX control register with stall and flush support. Sequences multi-cycle multiply/divide operations with a counter FSM that stalls the front end and pulses the HI/LO write enable.

## Interface
- `MUL_CYCLES`, default 4: EX busy cycles for mult. Legal range 1..255.
- `DIV_CYCLES`, default 32: EX busy cycles for div. Legal range 1..255.
- `ENABLE_MDU`, default 1: when 0, mult/div decode as illegal and the FSM is never entered.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `aluop` in 4: main-decoder ALU op.
- `func` in 6: R-type function field.
- `stall_in` in 1: hazard-unit stall; hold the ID/EX register.
- `flush` in 1: kill the EX contents (branch/jump redirect).
- `ex_valid` out 1: EX holds a valid instruction.
- `ex_alusel` out 4: registered ALU select.
- `ex_illegal` out 1: EX instruction failed decode.
- `stall_out` out 1: multi-cycle stall request to the hazard unit (combinational).
- `mdu_busy` out 1: FSM is in BUSY.
- `mdu_op` out 1: 0 = mult, 1 = div; valid while `mdu_busy` or `hilo_we`.
- `hilo_we` out 1: one-cycle HI/LO write pulse.

## Operation
- Decode is combinational.
- aluop 0000 (R-type), selected by func:
  - 100000 add=1, 100010 sub=2, 101010 slt=3, 100100 and=4, 100101 or=5
  - 100110 xor=10, 100111 nor=11, 000000 sll=12, 000010 srl=13
  - 011000 mult=14, 011010 div=15
- Other aluop codes, func ignored: 0011 lw=6, 1011 sw=7, 0100 beq=8, 0010 j=9.
- Anything else decodes to sel 0 with illegal=1. With `ENABLE_MDU`=0, mult and div also decode to sel 0 with illegal=1.
- ID/EX register update priority:
  1. `flush`: ex_valid=0, ex_alusel=0, ex_illegal=0.
  2. `stall_in` or `stall_out`: hold all fields.
  3. Otherwise: load `id_valid`, decoded sel, and `illegal & id_valid`.
- `mdu_start` = ex_valid & ex_alusel∈{14,15} & state==IDLE & !done_flag. `done_flag` is internal; it is set in DONE and cleared whenever the ID/EX register loads or flushes.
- FSM states:
  - IDLE: on `mdu_start`, cnt<=LAT-1 (LAT is MUL_CYCLES or DIV_CYCLES), latch mdu_op, go to BUSY.
  - BUSY: cnt decrements each cycle; when cnt==0, go to DONE.
  - DONE: hilo_we=1, set done_flag, go to IDLE.
- `stall_out` = mdu_start | (state==BUSY).
- A flush in any state forces IDLE on the next edge, clears cnt, and suppresses hilo_we. A flush in the DONE cycle itself does not cancel that cycle's pulse.
- `stall_in` during BUSY does not pause the counter.
- `stall_in` during DONE: hilo_we still pulses exactly once, and done_flag prevents a restart while the mult/div is still held in EX.

## Timing
- Reset values: ex_valid=0, ex_alusel=0, ex_illegal=0, hilo_we=0, mdu_busy=0, mdu_op=0, stall_out=0, state=IDLE, cnt=0, done_flag=0.
- Single-cycle ops: decode-to-EX latency is 1 cycle and there is no stall.
- Mult/div entering EX at cycle T:
  - stall_out is high in cycles T..T+LAT (LAT+1 cycles).
  - BUSY occupies T+1..T+LAT.
  - hilo_we pulses in cycle T+LAT+1.
  - The next instruction enters EX at edge T+LAT+2.
- Back-to-back mult/div: the second starts the cycle after it reaches EX; there are no extra bubbles.
- Reset asserted mid-BUSY clears everything immediately (asynchronously), with no hilo_we.

## Test plan
- Reset then ID add (aluop 0000, func 100000, id_valid=1) → the next cycle shows ex_valid=1, ex_alusel=1, stall_out=0.
- Sweep all 11 R-type funcs plus lw, sw, beq, j → ex_alusel matches the table; aluop 0111 → ex_alusel=0, ex_illegal=1.
- mult with MUL_CYCLES=4 entering EX at T → stall_out high T..T+4, mdu_busy high T+1..T+4, hilo_we single pulse at T+5, next op in EX at T+6.
- div with DIV_CYCLES=32, flush at BUSY cycle 10 → ex_valid=0 and state IDLE next cycle, no hilo_we, stall_out low.
- mult with stall_in held high through DONE and 3 further cycles → exactly one hilo_we pulse, no restart, ex_alusel stays 14 until stall_in drops.
- ENABLE_MDU=0, func 011000 → ex_alusel=0, ex_illegal=1, stall_out never asserted.
